// File: rtl/flit_link_tx.sv
// Credit-based flit link transmitter: flit FIFO, credit counter and packet-framing FSM.
// Optional macro FLIT_LINK_TX_FREE_WAIT_EN: after a tail flit, hold the next head until free_signal_i.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 16
`endif

module flit_link_tx #(
    parameter int N_BITS_POINTER = 3,
    parameter int N_BITS_CREDIT  = 5,
    parameter int MAX_CREDIT     = `MAX_PACKET_LENGHT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`FLIT_WIDTH-1:0] in_flit_i,
    input  logic                   in_valid_i,
    input  logic                   in_last_i,
    output logic                   in_ready_o,
    output logic [`FLIT_WIDTH-1:0] out_link_o,
    output logic                   is_valid_o,
    input  logic                   credit_signal_i,
    input  logic                   free_signal_i
);
    localparam int FW    = `FLIT_WIDTH;
    localparam int DEPTH = 1 << N_BITS_POINTER;
    localparam logic [N_BITS_POINTER:0]  COUNT_FULL = (N_BITS_POINTER + 1)'(DEPTH);
    localparam logic [N_BITS_CREDIT-1:0] CREDIT_MAX = N_BITS_CREDIT'(MAX_CREDIT);

`ifdef FLIT_LINK_TX_FREE_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_FREE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

    logic [FW:0]               mem_r [DEPTH];
    logic [N_BITS_POINTER-1:0] wr_ptr_r;
    logic [N_BITS_POINTER-1:0] rd_ptr_r;
    logic [N_BITS_POINTER:0]   count_r;
    logic [N_BITS_CREDIT-1:0]  credit_r;
    logic [N_BITS_CREDIT-1:0]  credit_nxt_s;
    logic [FW-1:0]             out_link_r;
    logic                      is_valid_r;
    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      full_s;
    logic                      empty_s;
    logic                      push_s;
    logic                      send_s;
    logic                      state_ok_s;
    logic                      head_last_s;
    logic [FW-1:0]             head_flit_s;

    assign full_s      = (count_r == COUNT_FULL);
    assign empty_s     = (count_r == '0);
    assign in_ready_o  = ~full_s;
    assign push_s      = in_valid_i & ~full_s;
    assign head_last_s = mem_r[rd_ptr_r][FW];
    assign head_flit_s = mem_r[rd_ptr_r][FW-1:0];
    assign send_s      = ~empty_s & (credit_r != '0) & state_ok_s;
    assign out_link_o  = out_link_r;
    assign is_valid_o  = is_valid_r;

`ifdef FLIT_LINK_TX_FREE_WAIT_EN
    assign state_ok_s = (state_r == IDLE) || (state_r == SEND);
`else
    logic unused_free_s;
    assign unused_free_s = free_signal_i;
    assign state_ok_s    = 1'b1;
`endif

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_last_i, in_flit_i};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + N_BITS_POINTER'(1'b1);
            end
            if (send_s) begin
                rd_ptr_r <= rd_ptr_r + N_BITS_POINTER'(1'b1);
            end
            if (push_s && !send_s) begin
                count_r <= count_r + (N_BITS_POINTER + 1)'(1'b1);
            end else if (send_s && !push_s) begin
                count_r <= count_r - (N_BITS_POINTER + 1)'(1'b1);
            end
        end
    end

    // Credit next value: simultaneous send and return cancel, returns saturate at the maximum
    always_comb begin
        credit_nxt_s = credit_r;
        if (send_s && !credit_signal_i) begin
            credit_nxt_s = credit_r - N_BITS_CREDIT'(1'b1);
        end else if (!send_s && credit_signal_i && (credit_r != CREDIT_MAX)) begin
            credit_nxt_s = credit_r + N_BITS_CREDIT'(1'b1);
        end else begin
            credit_nxt_s = credit_r;
        end
    end

    // Packet framing next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
`ifdef FLIT_LINK_TX_FREE_WAIT_EN
            IDLE: begin
                if (send_s) begin
                    state_nxt_s = head_last_s ? WAIT_FREE : SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (send_s && head_last_s) begin
                    state_nxt_s = WAIT_FREE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            WAIT_FREE: begin
                if (free_signal_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_FREE;
                end
            end
`else
            IDLE: begin
                if (send_s && !head_last_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (send_s && head_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
`endif
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, credit and registered link outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            credit_r   <= CREDIT_MAX;
            out_link_r <= '0;
            is_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            credit_r   <= credit_nxt_s;
            is_valid_r <= send_s;
            if (send_s) begin
                out_link_r <= head_flit_s;
            end
        end
    end

endmodule
